alu_issue_ctrl: RTL

Sequencing front end that drives the combinational ALU core. Accepts one operation per valid/ready request and decodes the 8-bit ALU opcode into the core's mode controls. Evaluates a 4-bit condition code against a held flag register (CPSR-like), then captures the core's result and flags. Returns a registered response. Sits between instruction decode and the ALU core.

---
 rtl/alu_issue_ctrl_pkg.sv | 90 +++++++++
 rtl/alu_issue_ctrl_cond_eval.sv | 47 ++++
 rtl/alu_issue_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue front end: opcodes, condition codes,
// flag bit indices, alu_ctrl field offsets, FSM states and the opcode decoder.
package alu_issue_ctrl_pkg;

  localparam logic [7:0] ALU_ADD   = 8'h00;
  localparam logic [7:0] ALU_SUB   = 8'h01;
  localparam logic [7:0] ALU_MULL  = 8'h02;
  localparam logic [7:0] ALU_UMULL = 8'h03;
  localparam logic [7:0] ALU_AND   = 8'h04;
  localparam logic [7:0] ALU_OR    = 8'h05;
  localparam logic [7:0] ALU_XOR   = 8'h06;
  localparam logic [7:0] ALU_NAND  = 8'h07;
  localparam logic [7:0] ALU_NOR   = 8'h08;
  localparam logic [7:0] ALU_XNOR  = 8'h09;
  localparam logic [7:0] ALU_CMP   = 8'h0A;
  localparam logic [7:0] ALU_LSL   = 8'h0B;
  localparam logic [7:0] ALU_LSR   = 8'h0C;
  localparam logic [7:0] ALU_ASL   = 8'h0D;
  localparam logic [7:0] ALU_ASR   = 8'h0E;
  localparam logic [7:0] ALU_ROR   = 8'h0F;
  localparam logic [7:0] ALU_FADD  = 8'h10;
  localparam logic [7:0] ALU_FSUB  = 8'h11;

  localparam logic [3:0] COND_AL = 4'd0;
  localparam logic [3:0] COND_EQ = 4'd1;
  localparam logic [3:0] COND_NE = 4'd2;
  localparam logic [3:0] COND_CS = 4'd3;
  localparam logic [3:0] COND_CC = 4'd4;
  localparam logic [3:0] COND_MI = 4'd5;
  localparam logic [3:0] COND_PL = 4'd6;
  localparam logic [3:0] COND_VS = 4'd7;
  localparam logic [3:0] COND_VC = 4'd8;
  localparam logic [3:0] COND_HI = 4'd9;
  localparam logic [3:0] COND_LS = 4'd10;
  localparam logic [3:0] COND_GE = 4'd11;
  localparam logic [3:0] COND_LT = 4'd12;
  localparam logic [3:0] COND_GT = 4'd13;
  localparam logic [3:0] COND_LE = 4'd14;
  localparam logic [3:0] COND_UN = 4'd15;

  // Flag vector order is {nan, subnormal, inf, cout, overflow, zero, negative}
  localparam int FLAG_N   = 0;
  localparam int FLAG_Z   = 1;
  localparam int FLAG_V   = 2;
  localparam int FLAG_C   = 3;
  localparam int FLAG_INF = 4;
  localparam int FLAG_SUB = 5;
  localparam int FLAG_NAN = 6;

  localparam int CTRL_ADD_SUB    = 0;
  localparam int CTRL_SIGNED_MUL = 1;
  localparam int CTRL_NEGATE     = 2;
  localparam int CTRL_SIGNED_CMP = 3;
  localparam int CTRL_FP_ADD_SUB = 4;
  localparam int CTRL_SHIFT_LSB  = 5;

  localparam logic [2:0] SHIFT_LSL = 3'd0;
  localparam logic [2:0] SHIFT_LSR = 3'd1;
  localparam logic [2:0] SHIFT_ASL = 3'd2;
  localparam logic [2:0] SHIFT_ASR = 3'd3;
  localparam logic [2:0] SHIFT_ROR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } issueState_e;

  // Unknown opcodes decode to all-zero controls and are passed through as-is
  function automatic logic [7:0] decodeCtrl(input logic [7:0] op);
    logic [7:0] ctrl;
    ctrl = 8'h00;
    case (op)
      ALU_SUB:                      ctrl[CTRL_ADD_SUB]    = 1'b1;
      ALU_MULL:                     ctrl[CTRL_SIGNED_MUL] = 1'b1;
      ALU_NAND, ALU_NOR, ALU_XNOR:  ctrl[CTRL_NEGATE]     = 1'b1;
      ALU_CMP:                      ctrl[CTRL_SIGNED_CMP] = 1'b1;
      ALU_FSUB:                     ctrl[CTRL_FP_ADD_SUB] = 1'b1;
      ALU_LSL: ctrl[CTRL_SHIFT_LSB +: 3] = SHIFT_LSL;
      ALU_LSR: ctrl[CTRL_SHIFT_LSB +: 3] = SHIFT_LSR;
      ALU_ASL: ctrl[CTRL_SHIFT_LSB +: 3] = SHIFT_ASL;
      ALU_ASR: ctrl[CTRL_SHIFT_LSB +: 3] = SHIFT_ASR;
      ALU_ROR: ctrl[CTRL_SHIFT_LSB +: 3] = SHIFT_ROR;
      ALU_ADD, ALU_UMULL, ALU_AND, ALU_OR, ALU_XOR, ALU_FADD: ctrl = 8'h00;
      default: ctrl = 8'h00;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_cond_eval.sv
// Condition-code evaluator: decides whether an op executes given the held
// flag register (N, Z, C, V and U = nan).
module alu_cond_eval
  import alu_issue_ctrl_pkg::*;
#(
  parameter int FLAGS_W = 7
) (
  input  logic [3:0]         cond,
  input  logic [FLAGS_W-1:0] flags,
  output logic               pass
);

  logic n, z, c, v, u;
  logic unused_flags;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];
  assign u = flags[FLAG_NAN];
  // inf and subnormal never take part in a condition
  assign unused_flags = flags[FLAG_INF] ^ flags[FLAG_SUB];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_AL: pass = 1'b1;
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_UN: pass = u;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/response sequencer around the combinational ALU core (IDLE->EXEC->RESP).
// Optional ALU_ISSUE_STATS_EN adds saturating executed/skipped op counters.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int FLAGS_W = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [7:0]         req_opcode,
  input  logic [WIDTH-1:0]   req_x,
  input  logic [WIDTH-1:0]   req_y,
  input  logic [3:0]         req_cond,
  input  logic               req_set_flags,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WIDTH-1:0]   resp_r,
  output logic [FLAGS_W-1:0] resp_flags,
  output logic               resp_executed,
  output logic [FLAGS_W-1:0] flags,
  output logic [WIDTH-1:0]   alu_x,
  output logic [WIDTH-1:0]   alu_y,
  output logic [7:0]         alu_opcode,
  output logic [7:0]         alu_ctrl,
  input  logic [WIDTH-1:0]   alu_r,
  input  logic [FLAGS_W-1:0] alu_flags
`ifdef ALU_ISSUE_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [15:0]        stat_exec,
  output logic [15:0]        stat_skip
`endif
);

  issueState_e state_q, state_d;

  logic [WIDTH-1:0]   aluX_q, aluX_d;
  logic [WIDTH-1:0]   aluY_q, aluY_d;
  logic [7:0]         aluOp_q, aluOp_d;
  logic [7:0]         aluCtrl_q, aluCtrl_d;
  logic [3:0]         cond_q, cond_d;
  logic               setFlags_q, setFlags_d;
  logic [FLAGS_W-1:0] flags_q, flags_d;
  logic [WIDTH-1:0]   respR_q, respR_d;
  logic [FLAGS_W-1:0] respFlags_q, respFlags_d;
  logic               respExec_q, respExec_d;
  logic               condPass;

  alu_cond_eval #(.FLAGS_W(FLAGS_W)) u_cond_eval (
    .cond  (cond_q),
    .flags (flags_q),
    .pass  (condPass)
  );

  always_comb begin
    state_d     = state_q;
    aluX_d      = aluX_q;
    aluY_d      = aluY_q;
    aluOp_d     = aluOp_q;
    aluCtrl_d   = aluCtrl_q;
    cond_d      = cond_q;
    setFlags_d  = setFlags_q;
    flags_d     = flags_q;
    respR_d     = respR_q;
    respFlags_d = respFlags_q;
    respExec_d  = respExec_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          aluX_d     = req_x;
          aluY_d     = req_y;
          aluOp_d    = req_opcode;
          aluCtrl_d  = decodeCtrl(req_opcode);
          cond_d     = req_cond;
          setFlags_d = req_set_flags;
          state_d    = ST_EXEC;
        end
      end
      // The core is combinational, so its outputs are already valid here
      ST_EXEC: begin
        respExec_d  = condPass;
        respFlags_d = flags_q;
        if (condPass) begin
          respR_d = alu_r;
          if (setFlags_q) begin
            flags_d     = alu_flags;
            respFlags_d = alu_flags;
          end
        end else begin
          respR_d = '0;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      aluX_q      <= '0;
      aluY_q      <= '0;
      aluOp_q     <= '0;
      aluCtrl_q   <= '0;
      cond_q      <= '0;
      setFlags_q  <= 1'b0;
      flags_q     <= '0;
      respR_q     <= '0;
      respFlags_q <= '0;
      respExec_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      aluX_q      <= aluX_d;
      aluY_q      <= aluY_d;
      aluOp_q     <= aluOp_d;
      aluCtrl_q   <= aluCtrl_d;
      cond_q      <= cond_d;
      setFlags_q  <= setFlags_d;
      flags_q     <= flags_d;
      respR_q     <= respR_d;
      respFlags_q <= respFlags_d;
      respExec_q  <= respExec_d;
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign resp_valid    = (state_q == ST_RESP);
  assign resp_r        = respR_q;
  assign resp_flags    = respFlags_q;
  assign resp_executed = respExec_q;
  assign flags         = flags_q;
  assign alu_x         = aluX_q;
  assign alu_y         = aluY_q;
  assign alu_opcode    = aluOp_q;
  assign alu_ctrl      = aluCtrl_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] statExec_q, statSkip_q;

  // Counters stick at all-ones rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      statExec_q <= '0;
      statSkip_q <= '0;
    end else if (stat_clr) begin
      statExec_q <= '0;
      statSkip_q <= '0;
    end else if (state_q == ST_EXEC) begin
      if (condPass && (statExec_q != 16'hFFFF)) begin
        statExec_q <= statExec_q + 16'd1;
      end
      if (!condPass && (statSkip_q != 16'hFFFF)) begin
        statSkip_q <= statSkip_q + 16'd1;
      end
    end
  end

  assign stat_exec = statExec_q;
  assign stat_skip = statSkip_q;
`endif

endmodule
